// File: rtl/spi_master_cmd.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cmd
// Purpose  : SPI mode-0 master that sends one 32-bit command frame
//            {cmd_code, cmd_data} per accepted request, MSB first, and
//            captures the 32-bit MISO response in the same frame.
// Ports    : clk, rst         - system clock, synchronous active-high reset
//            cmd_valid/ready  - request handshake (ready only in IDLE)
//            cmd_code/data    - 16-bit command and data fields
//            resp_valid       - one-cycle pulse when rx_data is updated
//            rx_data          - captured MISO word, first bit in bit 31
//            busy             - accept through end of inter-frame gap
//            cs_n/sclk/mosi   - SPI outputs (sclk idles low)
//            miso             - SPI input, already synchronised
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cmd #(
  parameter int CLK_DIV  = 4,  // sclk half-period in clk cycles, 2..255
  parameter int CS_SETUP = 4,  // cs_n low to start of first sclk low phase
  parameter int CS_HOLD  = 4,  // last sclk fall to cs_n high, >= 1
  parameter int CS_IDLE  = 8   // minimum cs_n high time between frames, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_code,
  input  logic [15:0] cmd_data,
  output logic        resp_valid,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [15:0] c_setup     = 16'(CS_SETUP);
  localparam logic [15:0] c_div_last  = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_hold_last = 16'(CS_HOLD - 1);
  localparam logic [15:0] c_idle_last = 16'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] tx_sr_q;
  logic [31:0] rx_sr_q;
  logic [31:0] rx_data_q;
  logic        cmd_ready_q;
  logic        busy_q;
  logic        resp_valid_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic        mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      bit_cnt_q    <= 6'd0;
      tx_sr_q      <= 32'd0;
      rx_sr_q      <= 32'd0;
      rx_data_q    <= 32'd0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            tx_sr_q     <= {cmd_code, cmd_data};
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= 16'd0;
            state_q     <= SETUP;
          end
        end

        // The first SETUP cycle drops cs_n (one cycle after accept); the
        // following CS_SETUP cycles are the chip-select setup time.
        SETUP: begin
          if (cnt_q == 16'd0) begin
            cs_n_q <= 1'b0;
            mosi_q <= tx_sr_q[31];
          end
          if (cnt_q == c_setup) begin
            cnt_q     <= 16'd0;
            bit_cnt_q <= 6'd0;
            state_q   <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        // Each half-period ends with an sclk toggle. MISO is sampled on the
        // rising toggle, the next MOSI bit is presented on the falling one.
        SHIFT: begin
          if (cnt_q == c_div_last) begin
            cnt_q  <= 16'd0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_sr_q <= {rx_sr_q[30:0], miso};
            end else if (bit_cnt_q == 6'd31) begin
              state_q <= HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
              tx_sr_q   <= {tx_sr_q[30:0], 1'b0};
              mosi_q    <= tx_sr_q[30];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        HOLD: begin
          if (cnt_q == c_hold_last) begin
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            rx_data_q    <= rx_sr_q;
            resp_valid_q <= 1'b1;
            cnt_q        <= 16'd0;
            state_q      <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        GAP: begin
          if (cnt_q == c_idle_last) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= 16'd0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign rx_data    = rx_data_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cmd
// Purpose  : Directed self-checking bench for spi_master_cmd. Two instances
//            share clk/rst: index 0 uses CLK_DIV=2, index 1 uses CLK_DIV=255.
//            A negedge monitor acts as the SPI slave (MISO changes after each
//            sclk fall) and records MOSI words, timing and protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cmd;

  localparam int DIV0     = 2;
  localparam int DIV1     = 255;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 8;

  logic        clk;
  logic        rst;
  logic        valid      [2];
  logic        ready      [2];
  logic [15:0] code       [2];
  logic [15:0] data       [2];
  logic        resp_valid [2];
  logic [31:0] rx_data    [2];
  logic        busy       [2];
  logic        cs_n       [2];
  logic        sclk       [2];
  logic        mosi       [2];
  logic        miso       [2];

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // monitor / slave-model state
  logic [31:0] slave_word [2];
  logic [31:0] mosi_sr    [2];
  logic [31:0] last_mosi  [2];
  logic        prev_cs    [2];
  logic        prev_sclk  [2];
  logic        seen_rise  [2];
  int          rise_cnt   [2];
  int          last_rises [2];
  int          sidx       [2];
  int          ph_len     [2];
  int          phase_bad  [2];
  int          proto_bad  [2];
  int          resp_cnt   [2];
  int          t_fall     [2];
  int          t_rise     [2];
  logic [31:0] mosi_log [$];
  int          gap_log  [$];

  spi_master_cmd #(.CLK_DIV(DIV0), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_code(code[0]), .cmd_data(data[0]), .resp_valid(resp_valid[0]),
    .rx_data(rx_data[0]), .busy(busy[0]), .cs_n(cs_n[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0]));

  spi_master_cmd #(.CLK_DIV(DIV1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut_slow (
    .clk(clk), .rst(rst), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_code(code[1]), .cmd_data(data[1]), .resp_valid(resp_valid[1]),
    .rx_data(rx_data[1]), .busy(busy[1]), .cs_n(cs_n[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_cs[k] = 1'b1;   prev_sclk[k] = 1'b0; seen_rise[k] = 1'b0;
      mosi_sr[k] = 32'd0;  last_mosi[k] = 32'd0; rise_cnt[k] = 0;
      last_rises[k] = 0;   sidx[k] = 0;          ph_len[k] = 0;
      phase_bad[k] = 0;    proto_bad[k] = 0;     resp_cnt[k] = 0;
      t_fall[k] = 0;       t_rise[k] = 0;        miso[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] w;
      int          div;
      div = (k == 0) ? DIV0 : DIV1;
      if (cs_n[k] === 1'b0 && prev_cs[k] === 1'b1) begin
        if (k == 0 && seen_rise[0]) gap_log.push_back(cyc - t_rise[0]);
        t_fall[k]   = cyc;
        rise_cnt[k] = 0;
        mosi_sr[k]  = 32'd0;
        sidx[k]     = 0;
      end
      if (cs_n[k] === 1'b1 && prev_cs[k] === 1'b0) begin
        t_rise[k]     = cyc;
        seen_rise[k]  = 1'b1;
        last_mosi[k]  = mosi_sr[k];
        last_rises[k] = rise_cnt[k];
        if (k == 0) mosi_log.push_back(mosi_sr[0]);
      end
      if (sclk[k] !== prev_sclk[k]) begin
        if (prev_cs[k] === 1'b1 && cs_n[k] === 1'b1) proto_bad[k]++;
        if (cs_n[k] === 1'b0 && prev_cs[k] === 1'b0 &&
            (sclk[k] === 1'b0 || rise_cnt[k] != 0) && ph_len[k] != div)
          phase_bad[k]++;
        ph_len[k] = 1;
        if (sclk[k] === 1'b1) begin
          rise_cnt[k]++;
          mosi_sr[k] = {mosi_sr[k][30:0], mosi[k]};
        end else begin
          sidx[k]++;
        end
      end else begin
        ph_len[k]++;
      end
      if (cs_n[k] !== prev_cs[k] && sclk[k] === 1'b1) proto_bad[k]++;
      if (resp_valid[k] === 1'b1) begin
        resp_cnt[k]++;
        if (!(cs_n[k] === 1'b1 && prev_cs[k] === 1'b0)) proto_bad[k]++;
      end
      w = slave_word[k];
      if (cs_n[k] !== 1'b0) miso[k] = w[31];
      else if (sidx[k] < 32) miso[k] = w[31 - sidx[k]];
      else miso[k] = 1'b0;
      prev_sclk[k] = sclk[k];
      prev_cs[k]   = cs_n[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int k, input logic [15:0] c, input logic [15:0] d,
                            input logic [31:0] sw);
    int acc, rdy, r0, p0, q0, n, div;
    bit ok;
    div = (k == 0) ? DIV0 : DIV1;
    slave_word[k] = sw;
    @(negedge clk);
    r0 = resp_cnt[k]; p0 = phase_bad[k]; q0 = proto_bad[k];
    valid[k] = 1'b1; code[k] = c; data[k] = d;
    n = 0;
    while (ready[k] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc = cyc;
    chk("ready_busy_after_accept", 32'({ready[k], busy[k]}), 32'b01);
    @(negedge clk);
    valid[k] = 1'b0; code[k] = ~c; data[k] = ~d;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (ready[k] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    rdy = cyc;
    chk("ready_return", 32'(ok), 32'd1);
    chk("cs_fall_latency", 32'(t_fall[k] - acc), 32'd1);
    chk("cs_low_cycles", 32'(t_rise[k] - t_fall[k]), 32'(CS_SETUP + 64 * div + CS_HOLD));
    chk("accept_to_ready", 32'(rdy - acc), 32'(1 + CS_SETUP + 64 * div + CS_HOLD + CS_IDLE));
    chk("sclk_rises", 32'(last_rises[k]), 32'd32);
    chk("mosi_word", last_mosi[k], {c, d});
    chk("rx_data", rx_data[k], sw);
    chk("resp_pulses", 32'(resp_cnt[k] - r0), 32'd1);
    chk("sclk_phase_errors", 32'(phase_bad[k] - p0), 32'd0);
    chk("protocol_errors", 32'(proto_bad[k] - q0), 32'd0);
  endtask

  initial begin
    int n, r0, q0, ls, gs;
    logic [15:0] qc [3];
    logic [15:0] qd [3];

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      valid[k] = 1'b1; code[k] = 16'hFFFF; data[k] = 16'hFFFF;
      slave_word[k] = 32'h0;
    end
    repeat (4) @(negedge clk);
    // requests presented during reset must be ignored
    chk("reset_outputs", 32'({cs_n[0], sclk[0], mosi[0], ready[0], busy[0], resp_valid[0]}), 32'b100100);
    chk("reset_rx_data", rx_data[0], 32'd0);
    chk("reset_outputs_slow", 32'({cs_n[1], sclk[1], mosi[1], ready[1], busy[1], resp_valid[1]}), 32'b100100);
    valid[0] = 1'b0; valid[1] = 1'b0;
    rst = 1'b0;

    // machine start frame
    send_frame(0, 16'h0001, 16'h0000, 32'h0F0F0F0F);

    // three requests queued with cmd_valid held high
    qc[0] = 16'h0003; qd[0] = 16'h00C8;
    qc[1] = 16'h0004; qd[1] = 16'h0190;
    qc[2] = 16'h0005; qd[2] = 16'h0020;
    slave_word[0] = 32'hA5C3_3C5A;
    ls = mosi_log.size(); gs = gap_log.size(); r0 = resp_cnt[0]; q0 = proto_bad[0];
    @(negedge clk);
    valid[0] = 1'b1; code[0] = qc[0]; data[0] = qd[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (ready[0] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      if (i < 2) begin code[0] = qc[i + 1]; data[0] = qd[i + 1]; end
      else valid[0] = 1'b0;
    end
    n = 0;
    while (ready[0] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("queued_frames_logged", 32'(mosi_log.size() - ls), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("queued_mosi_word", (mosi_log.size() > ls + i) ? mosi_log[ls + i] : 32'hDEAD_DEAD, {qc[i], qd[i]});
    for (int i = 0; i < 2; i++)
      chk("queued_cs_gap_ge_8", 32'((gap_log.size() > gs + i) ? (gap_log[gs + i] >= CS_IDLE) : 0), 32'd1);
    chk("queued_resp_pulses", 32'(resp_cnt[0] - r0), 32'd3);
    chk("queued_rx_data", rx_data[0], 32'hA5C3_3C5A);
    chk("queued_protocol_errors", 32'(proto_bad[0] - q0), 32'd0);

    // reset in the middle of SHIFT, around bit 10
    slave_word[0] = 32'h1234_5678;
    @(negedge clk);
    valid[0] = 1'b1; code[0] = 16'h0002; data[0] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    n = 0;
    while (rise_cnt[0] < 10 && n < 500) begin @(negedge clk); n++; end
    r0 = resp_cnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_cs_sclk_mosi", 32'({cs_n[0], sclk[0], mosi[0]}), 32'b100);
    chk("midreset_rx_data", rx_data[0], 32'd0);
    chk("midreset_ready_busy", 32'({ready[0], busy[0], resp_valid[0]}), 32'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_no_resp", 32'(resp_cnt[0] - r0), 32'd0);
    send_frame(0, 16'hBEEF, 16'h0042, 32'hC3A5_5A3C);

    // random payload sweeps on both clock dividers
    for (int i = 0; i < 3; i++)
      send_frame(0, 16'($urandom), 16'($urandom), $urandom);
    for (int i = 0; i < 2; i++)
      send_frame(1, 16'($urandom), 16'($urandom), $urandom);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
